// File: rtl/ped_crossing_pkg.sv
// Shared types for the pedestrian crossing controller: FSM states, lamp
// vector layout and a lamp population helper.
package ped_crossing_pkg;

  typedef enum logic [1:0] {
    DONT_WALK = 2'd0,
    WALK      = 2'd1,
    FLASH     = 2'd2,
    FAULT     = 2'd3
  } ped_state_e;

  localparam int unsigned LAMP_W = 4;
  localparam int unsigned LG     = 0;
  localparam int unsigned G      = 1;
  localparam int unsigned A      = 2;
  localparam int unsigned R      = 3;

  typedef logic [LAMP_W-1:0] lamp_vec_t;

  // Number of vehicle lamps lit; a healthy sequencer shows exactly one.
  function automatic logic [2:0] lamp_count(input lamp_vec_t l);
    return 3'(l[LG]) + 3'(l[G]) + 3'(l[A]) + 3'(l[R]);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Lamp inputs, push-button and pedestrian outputs of the crossing controller.
interface ped_crossing_ctrl_if #(
  parameter int unsigned CNT_W = 4
);

  logic             LeftGreen;
  logic             Green;
  logic             Amber;
  logic             Red;
  logic             PED_REQ;
  logic             PED_WALK;
  logic             PED_DONT_WALK;
  logic             PED_WAIT;
  logic             PED_ACK;
  logic             PED_ABORT;
  logic             FAULT;
  logic [CNT_W-1:0] COUNTDOWN;

  // master drives the lamps and button; slave is the crossing controller
  modport master (
    output LeftGreen, Green, Amber, Red, PED_REQ,
    input  PED_WALK, PED_DONT_WALK, PED_WAIT, PED_ACK, PED_ABORT, FAULT, COUNTDOWN
  );

  modport slave (
    input  LeftGreen, Green, Amber, Red, PED_REQ,
    output PED_WALK, PED_DONT_WALK, PED_WAIT, PED_ACK, PED_ABORT, FAULT, COUNTDOWN
  );

endinterface

// File: rtl/stoplight_lamp_monitor.sv
// Watches the vehicle lamps: flags the Red rising edge and any lamp
// combination other than exactly-one-lit once the sequencer has started.
module stoplight_lamp_monitor
  import ped_crossing_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic LeftGreen,
  input  logic Green,
  input  logic Amber,
  input  logic Red,
  output logic red_rise,
  output logic illegal
);

  lamp_vec_t  lamps;
  logic       one_hot;
  logic       red_d;
  logic       armed;

  always_comb begin
    lamps     = '0;
    lamps[LG] = LeftGreen;
    lamps[G]  = Green;
    lamps[A]  = Amber;
    lamps[R]  = Red;
  end

  assign one_hot  = (lamp_count(lamps) == 3'd1);
  assign red_rise = Red & ~red_d;
  assign illegal  = armed & ~one_hot;

  // red_d resets high so a Red already lit out of reset is not an edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      red_d <= 1'b1;
      armed <= 1'b0;
    end else begin
      red_d <= Red;
      if (one_hot) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests and grants a
// WALK / flashing DONT WALK window inside the vehicle Red phase.
module ped_crossing_ctrl
  import ped_crossing_pkg::*;
#(
  parameter int unsigned WALK_STEPS  = 2,
  parameter int unsigned FLASH_STEPS = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  ped_crossing_ctrl_if.slave pif
);

  ped_state_e       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             req_q, req_n;
  logic             grant;
  logic             red_rise;
  logic             illegal;

  logic             walk_q, walk_n;
  logic             dont_walk_q, dont_walk_n;
  logic             ack_q, ack_n;
  logic             abort_q, abort_n;
  logic             fault_q, fault_n;
  logic [CNT_W-1:0] countdown_q, countdown_n;

  stoplight_lamp_monitor u_monitor (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .LeftGreen (pif.LeftGreen),
    .Green     (pif.Green),
    .Amber     (pif.Amber),
    .Red       (pif.Red),
    .red_rise  (red_rise),
    .illegal   (illegal)
  );

  // Next state: illegal lamps beat Red dropping, which beats the counter.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    grant   = 1'b0;
    abort_n = 1'b0;
    if (illegal) begin
      state_n = FAULT;
      cnt_n   = '0;
    end else begin
      case (state_q)
        DONT_WALK: begin
          if (red_rise && req_q) begin
            state_n = WALK;
            cnt_n   = CNT_W'(WALK_STEPS - 1);
            grant   = 1'b1;
          end
        end
        WALK: begin
          if (!pif.Red) begin
            state_n = DONT_WALK;
            cnt_n   = '0;
            abort_n = 1'b1;
          end else if (cnt_q == '0) begin
            state_n = FLASH;
            cnt_n   = CNT_W'(FLASH_STEPS - 1);
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        FLASH: begin
          if (!pif.Red) begin
            state_n = DONT_WALK;
            cnt_n   = '0;
            abort_n = 1'b1;
          end else if (cnt_q == '0) begin
            state_n = DONT_WALK;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        FAULT: begin
          state_n = FAULT;
        end
        default: begin
          state_n = FAULT;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Request latch is frozen once faulted; a grant consumes any same-cycle press.
  always_comb begin
    req_n = req_q;
    if (state_q != FAULT) begin
      if (grant)            req_n = 1'b0;
      else if (pif.PED_REQ) req_n = 1'b1;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    ack_n       = grant;
    walk_n      = (state_n == WALK);
    fault_n     = (state_n == FAULT);
    dont_walk_n = 1'b1;
    countdown_n = '0;
    if (state_n == WALK) begin
      dont_walk_n = 1'b0;
    end else if (state_n == FLASH && state_q == FLASH) begin
      dont_walk_n = ~dont_walk_q;
    end
    if (state_n == WALK || state_n == FLASH) begin
      countdown_n = cnt_n;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= DONT_WALK;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      ack_q       <= 1'b0;
      abort_q     <= 1'b0;
      fault_q     <= 1'b0;
      countdown_q <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      req_q       <= req_n;
      walk_q      <= walk_n;
      dont_walk_q <= dont_walk_n;
      ack_q       <= ack_n;
      abort_q     <= abort_n;
      fault_q     <= fault_n;
      countdown_q <= countdown_n;
    end
  end

  assign pif.PED_WALK      = walk_q;
  assign pif.PED_DONT_WALK = dont_walk_q;
  assign pif.PED_WAIT      = req_q;
  assign pif.PED_ACK       = ack_q;
  assign pif.PED_ABORT     = abort_q;
  assign pif.FAULT         = fault_q;
  assign pif.COUNTDOWN     = countdown_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: reset, normal crossing, idle Red,
// abort, late requests, async reset mid-crossing and sticky fault.
module tb_ped_crossing_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  ped_crossing_ctrl_if #(.CNT_W(4)) pif ();

  ped_crossing_ctrl #(
    .WALK_STEPS  (2),
    .FLASH_STEPS (2),
    .CNT_W       (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lamps(input logic lg, input logic g, input logic a, input logic r);
    pif.LeftGreen = lg;
    pif.Green     = g;
    pif.Amber     = a;
    pif.Red       = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lamps(1'b0, 1'b0, 1'b0, 1'b0);
    pif.PED_REQ = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    pif.PED_REQ = 1'b0;
    lamps(1'b0, 1'b0, 1'b0, 1'b1);

    // reset with Red held high
    tick();
    tick();
    check("rst_dont_walk", int'(pif.PED_DONT_WALK), 1);
    check("rst_walk",      int'(pif.PED_WALK), 0);
    check("rst_wait",      int'(pif.PED_WAIT), 0);
    check("rst_ack",       int'(pif.PED_ACK), 0);
    check("rst_abort",     int'(pif.PED_ABORT), 0);
    check("rst_fault",     int'(pif.FAULT), 0);
    check("rst_countdown", int'(pif.COUNTDOWN), 0);
    rst_n = 1'b1;
    pif.PED_REQ = 1'b1;
    tick();
    check("rst_nogrant_ack",  int'(pif.PED_ACK), 0);
    check("rst_nogrant_walk", int'(pif.PED_WALK), 0);
    check("rst_req_latched",  int'(pif.PED_WAIT), 1);
    pif.PED_REQ = 1'b0;
    tick();
    check("rst_still_noack", int'(pif.PED_ACK), 0);

    // normal crossing
    do_reset();
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("norm_wait_idle", int'(pif.PED_WAIT), 0);
    pif.PED_REQ = 1'b1;
    tick();
    check("norm_wait_set", int'(pif.PED_WAIT), 1);
    pif.PED_REQ = 1'b0;
    lamps(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("norm_wait_amber", int'(pif.PED_WAIT), 1);
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("norm_t1_ack",  int'(pif.PED_ACK), 1);
    check("norm_t1_walk", int'(pif.PED_WALK), 1);
    check("norm_t1_dw",   int'(pif.PED_DONT_WALK), 0);
    check("norm_t1_cd",   int'(pif.COUNTDOWN), 1);
    check("norm_t1_wait", int'(pif.PED_WAIT), 0);
    tick();
    check("norm_t2_ack",  int'(pif.PED_ACK), 0);
    check("norm_t2_walk", int'(pif.PED_WALK), 1);
    check("norm_t2_cd",   int'(pif.COUNTDOWN), 0);
    tick();
    check("norm_t3_walk", int'(pif.PED_WALK), 0);
    check("norm_t3_dw",   int'(pif.PED_DONT_WALK), 1);
    check("norm_t3_cd",   int'(pif.COUNTDOWN), 1);
    tick();
    check("norm_t4_dw", int'(pif.PED_DONT_WALK), 0);
    check("norm_t4_cd", int'(pif.COUNTDOWN), 0);
    tick();
    check("norm_t5_dw",    int'(pif.PED_DONT_WALK), 1);
    check("norm_t5_walk",  int'(pif.PED_WALK), 0);
    check("norm_t5_abort", int'(pif.PED_ABORT), 0);

    // Red phase with no request pending
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    lamps(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("noreq_walk%0d", i), int'(pif.PED_WALK), 0);
      check($sformatf("noreq_ack%0d", i),  int'(pif.PED_ACK), 0);
    end

    // Red drops during WALK
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    pif.PED_REQ = 1'b1;
    tick();
    pif.PED_REQ = 1'b0;
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("abort_t1_ack", int'(pif.PED_ACK), 1);
    tick();
    check("abort_t2_walk", int'(pif.PED_WALK), 1);
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("abort_dw",    int'(pif.PED_DONT_WALK), 1);
    check("abort_walk",  int'(pif.PED_WALK), 0);
    check("abort_pulse", int'(pif.PED_ABORT), 1);
    check("abort_cd",    int'(pif.COUNTDOWN), 0);
    tick();
    check("abort_pulse_end", int'(pif.PED_ABORT), 0);

    // requests while Red already high, and during WALK
    lamps(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("late_rise_noack", int'(pif.PED_ACK), 0);
    pif.PED_REQ = 1'b1;
    tick();
    check("late_wait", int'(pif.PED_WAIT), 1);
    check("late_ack0", int'(pif.PED_ACK), 0);
    pif.PED_REQ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("late_nowalk%0d", i), int'(pif.PED_WALK), 0);
      check($sformatf("late_noack%0d", i),  int'(pif.PED_ACK), 0);
    end
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("late_wait_green", int'(pif.PED_WAIT), 1);
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("late_grant_ack",  int'(pif.PED_ACK), 1);
    check("late_grant_wait", int'(pif.PED_WAIT), 0);
    pif.PED_REQ = 1'b1;
    tick();
    check("late_walk_req_walk", int'(pif.PED_WALK), 1);
    check("late_walk_req_wait", int'(pif.PED_WAIT), 1);
    pif.PED_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("late_regrant_none%0d", i), int'(pif.PED_ACK), 0);
    end
    check("late_end_dw",   int'(pif.PED_DONT_WALK), 1);
    check("late_end_wait", int'(pif.PED_WAIT), 1);
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("late_next_ack",  int'(pif.PED_ACK), 1);
    check("late_next_walk", int'(pif.PED_WALK), 1);

    // asynchronous reset while walking
    #2;
    rst_n = 1'b0;
    #1;
    check("async_walk", int'(pif.PED_WALK), 0);
    check("async_dw",   int'(pif.PED_DONT_WALK), 1);
    check("async_cd",   int'(pif.COUNTDOWN), 0);
    check("async_wait", int'(pif.PED_WAIT), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("async_rel_noack", int'(pif.PED_ACK), 0);

    // illegal lamps make a sticky fault
    lamps(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("ill_fault", int'(pif.FAULT), 1);
    check("ill_dw",    int'(pif.PED_DONT_WALK), 1);
    check("ill_walk",  int'(pif.PED_WALK), 0);
    lamps(1'b0, 1'b1, 1'b0, 1'b0);
    pif.PED_REQ = 1'b1;
    tick();
    check("ill_hold_green", int'(pif.FAULT), 1);
    pif.PED_REQ = 1'b0;
    lamps(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("ill_hold_red",  int'(pif.FAULT), 1);
    check("ill_no_ack",    int'(pif.PED_ACK), 0);
    check("ill_no_walk",   int'(pif.PED_WALK), 0);
    tick();
    check("ill_hold_late", int'(pif.FAULT), 1);
    do_reset();
    check("ill_cleared", int'(pif.FAULT), 0);
    check("ill_clr_dw",  int'(pif.PED_DONT_WALK), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Downstream consumer of the four-lamp stoplight sequencer (LeftGreen/Green/Amber/Red, one step per CLK).
- Latches pedestrian push-button requests and grants a WALK then flashing DONT WALK window inside the vehicle Red phase.
- Aborts the crossing immediately if Red drops.
- Detects illegal lamp combinations and holds a sticky fault.

Parameters:
- WALK_STEPS, 2, CLK steps of steady WALK (>=1).
- FLASH_STEPS, 2, CLK steps of flashing DONT WALK (>=1). WALK_STEPS+FLASH_STEPS must not exceed the vehicle Red length (5).
- CNT_W, 4, countdown width; must hold max(WALK_STEPS,FLASH_STEPS)-1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LeftGreen  in  1  vehicle turn-arrow lamp, registered in CLK domain.
- Green  in  1  vehicle green lamp.
- Amber  in  1  vehicle amber lamp.
- Red  in  1  vehicle red lamp.
- PED_REQ  in  1  push-button, already synchronous, level.
- PED_WALK  out  1  walk lamp.
- PED_DONT_WALK  out  1  don't-walk lamp.
- PED_WAIT  out  1  request pending.
- PED_ACK  out  1  one-cycle pulse on grant.
- PED_ABORT  out  1  one-cycle pulse on early termination.
- FAULT  out  1  sticky illegal-lamp flag.
- COUNTDOWN  out  CNT_W  steps remaining in the current WALK/FLASH phase.

Behaviour:
- Single clock CLK; asynchronous active-low reset RST_N.
- All outputs are registered and respond 1 cycle after the input edge.
- Reset values:
  - PED_WALK=0, PED_DONT_WALK=1.
  - PED_WAIT=0, PED_ACK=0, PED_ABORT=0, FAULT=0, COUNTDOWN=0.
  - State DONT_WALK, armed=0, red_d=1. With red_d=1, no grant can occur on a Red already high out of reset.
- Monitor:
  - red_rise = Red & ~red_d.
  - armed sets on the first cycle with exactly one lamp high. Lamps are undefined before the sequencer's first step, so no checks run before then.
  - illegal = armed & (number of lamps high != 1).
- Request latch:
  - req_q sets when PED_REQ=1. It clears on the grant cycle; a PED_REQ high on the grant cycle is consumed by that grant.
  - PED_WAIT = req_q.
- FSM states: DONT_WALK, WALK, FLASH, FAULT. Priority within a cycle: illegal > Red low > counter.
- DONT_WALK:
  - Outputs: PED_DONT_WALK=1, PED_WALK=0.
  - If red_rise & req_q: go to WALK, cnt=WALK_STEPS-1, PED_ACK=1.
  - A request arriving while Red is already high waits for the next red_rise; partial windows are never granted.
- WALK:
  - Outputs: PED_WALK=1, PED_DONT_WALK=0.
  - Red=0: go to DONT_WALK, PED_ABORT=1.
  - cnt==0: go to FLASH, cnt=FLASH_STEPS-1.
  - Otherwise cnt decrements.
- FLASH:
  - Outputs: PED_WALK=0. PED_DONT_WALK=1 on the first FLASH cycle, then toggles every cycle.
  - Red=0: go to DONT_WALK, PED_ABORT=1.
  - cnt==0: go to DONT_WALK (normal completion, no abort).
- FAULT:
  - Entered from any state on illegal.
  - Outputs: PED_DONT_WALK=1, PED_WALK=0, FAULT=1.
  - PED_ACK is suppressed and req_q is held.
  - Exits only on RST_N.
- COUNTDOWN = cnt in WALK/FLASH, 0 otherwise.
- Requests during WALK/FLASH set req_q and are served at the next red_rise.
- An abort does not clear or set req_q beyond the normal latch rules.
- Reset mid-crossing: forced to reset values asynchronously; the lamp goes to DONT WALK immediately.

Decomposition:
- Package ped_crossing_pkg:
  - State enum {DONT_WALK, WALK, FLASH, FAULT}.
  - Lamp index constants LG=0, G=1, A=2, R=3 for the packed lamp vector.
- Sub-module stoplight_lamp_monitor:
  - Inputs: CLK, RST_N, four lamps.
  - Outputs: red_rise, illegal.
  - Holds red_d and armed.
- Top holds req_q, cnt, and the FSM.

Test Plan:
- Reset with Red=1 held: PED_DONT_WALK=1, all other outputs 0, and no grant in the first cycle after release even with PED_REQ=1.
- Normal crossing, defaults. PED_REQ pulsed during Green, Red rises at edge T:
  - T+1: PED_ACK=1, PED_WALK=1, COUNTDOWN=1.
  - T+2: PED_WALK=1, COUNTDOWN=0.
  - T+3 to T+4: FLASH with PED_DONT_WALK=1 then 0, COUNTDOWN 1 then 0.
  - T+5: PED_DONT_WALK steady 1.
  - PED_WAIT is 1 from the request until T+1.
- No request: Red rises and stays high 5 cycles; PED_WALK stays 0, PED_ACK never pulses.
- Abort: Red drops at T+2 during WALK; next cycle PED_DONT_WALK=1, PED_ABORT=1 for one cycle, COUNTDOWN=0.
- Late request (PED_REQ high while Red is already high, and again during WALK): no grant in the current Red. PED_WAIT=1 until the next red_rise, then ACK.
- Illegal: after armed, drive Green=1 and Red=1 together. Next cycle FAULT=1, DONT_WALK. FAULT holds through later legal lamps and red_rise; it clears only on RST_N.
